// File: rtl/mem_pkg.sv
// Shared types and widths for the memory arbiter slice.
package mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    localparam int unsigned MEM_MASK_W = 4;
    localparam int unsigned WORD_W     = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data has priority unless fetch has waited out a full streak.
module mem_arb_pick #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned SW           = 3
) (
    input  logic          i_valid,
    input  logic          d_valid,
    input  logic [SW-1:0] streak,
    output logic          grant_i,
    output logic          grant_d
);

    logic starve;

    always_comb begin
        starve  = i_valid && (streak == SW'(MAX_D_STREAK));
        grant_d = d_valid && !starve;
        grant_i = i_valid && !grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data load/store.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [31:0]       i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_mask,
    output logic              d_resp_valid,
    output logic [31:0]       d_resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    owner_t        owner_q, owner_d;
    logic          grant_i, grant_d;
    logic          i_valid_g, d_valid_g;

    // Valids are masked during reset so no grant (and no memory access) can occur.
    assign i_valid_g = i_req_valid && !rst;
    assign d_valid_g = d_req_valid && !rst;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_pick (
        .i_valid (i_valid_g),
        .d_valid (d_valid_g),
        .streak  (streak_q),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        streak_d = streak_q;
        if (!i_req_valid || grant_i) begin
            streak_d = '0;
        end else if (grant_d && streak_q != SW'(MAX_D_STREAK)) begin
            streak_d = streak_q + 1'b1;
        end

        owner_d = OWN_NONE;
        if (grant_i) begin
            owner_d = OWN_I;
        end else if (grant_d) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (grant_i) begin
            mem_addr = i_req_addr;
            mem_ren  = 1'b1;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
            if (d_req_we) begin
                mem_wen   = 1'b1;
                mem_wdata = d_req_wdata;
                mem_mask  = d_req_mask;
            end else begin
                mem_ren = 1'b1;
            end
        end
    end

    // A grant followed by reset is dropped, so the response bits are also masked by rst.
    always_comb begin
        i_req_ready  = grant_i;
        d_req_ready  = grant_d;
        i_resp_valid = (owner_q == OWN_I) && !rst;
        d_resp_valid = (owner_q == OWN_D) && !rst;
        i_resp_data  = i_resp_valid ? mem_rdata : '0;
        d_resp_data  = d_resp_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural byte-masked memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;
    logic [3:0]  mem_mask;

    logic [31:0] mem [0:63];
    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wdata  (d_req_wdata),
        .d_req_mask   (d_req_mask),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .mem_addr     (mem_addr),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_mask     (mem_mask),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req_valid = 1'b1; d_req_valid = 1'b1;
        i_req_addr = 32'h10; d_req_addr = 32'h4; d_req_we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests_run++;
            if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_ren, mem_wen} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 000000", c,
                         {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_ren, mem_wen});
            end
            step();
        end
        rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
        settle();
        tests_run++;
        if ({i_resp_valid, d_resp_valid, mem_ren, mem_wen} !== 4'b0 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_release: resp %b%b ren/wen %b%b addr %h, expected all 0",
                     i_resp_valid, d_resp_valid, mem_ren, mem_wen, mem_addr);
        end
        step();
    endtask

    task automatic test_lone_fetch();
        i_req_valid = 1'b1; i_req_addr = 32'h10;
        settle();
        tests_run++;
        if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL lone_fetch_grant: ready %b/%b ren %b addr %h, expected 1/0 1 00000010",
                     i_req_ready, d_req_ready, mem_ren, mem_addr);
        end
        step();
        i_req_valid = 1'b0;
        settle();
        tests_run++;
        if (i_resp_valid !== 1'b1 || i_resp_data !== 32'hA000_0004 || d_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lone_fetch_resp: valid %b data %h dvalid %b, expected 1 a0000004 0",
                     i_resp_valid, i_resp_data, d_resp_valid);
        end
        step();
    endtask

    task automatic test_priority();
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0;
        settle();
        tests_run++;
        if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0 || mem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL priority_d_first: d/i ready %b/%b addr %h, expected 1/0 00000004",
                     d_req_ready, i_req_ready, mem_addr);
        end
        step();
        d_req_valid = 1'b0;
        settle();
        tests_run++;
        if (d_resp_valid !== 1'b1 || d_resp_data !== 32'hA000_0001 || i_req_ready !== 1'b1 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL priority_i_second: dvalid %b ddata %h iready %b addr %h, expected 1 a0000001 1 00000000",
                     d_resp_valid, d_resp_data, i_req_ready, mem_addr);
        end
        step();
        i_req_valid = 1'b0;
        settle();
        tests_run++;
        if (i_resp_valid !== 1'b1 || i_resp_data !== 32'hA000_0000 || d_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL priority_i_resp: valid %b data %h dvalid %b, expected 1 a0000000 0",
                     i_resp_valid, i_resp_data, d_resp_valid);
        end
        step();
    endtask

    task automatic test_writes();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h8;
        d_req_wdata = 32'h1122_3344; d_req_mask = 4'b1111;
        settle();
        tests_run++;
        if (d_req_ready !== 1'b1 || mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_mask !== 4'hF || mem_wdata !== 32'h1122_3344) begin
            tests_failed++;
            $display("FAIL write_drive: ready %b wen %b ren %b mask %h wdata %h, expected 1 1 0 f 11223344",
                     d_req_ready, mem_wen, mem_ren, mem_mask, mem_wdata);
        end
        step();
        d_req_wdata = 32'hAABB_CCDD; d_req_mask = 4'b0011;
        settle();
        tests_run++;
        if (d_resp_valid !== 1'b1 || mem_mask !== 4'b0011) begin
            tests_failed++;
            $display("FAIL write_ack1: dvalid %b mask %b, expected 1 0011", d_resp_valid, mem_mask);
        end
        step();
        d_req_wdata = 32'hFFFF_FFFF; d_req_mask = 4'b0000;
        settle();
        tests_run++;
        if (d_resp_valid !== 1'b1 || d_req_ready !== 1'b1 || mem_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_ack2_zero_mask_grant: dvalid %b ready %b wen %b, expected 1 1 1",
                     d_resp_valid, d_req_ready, mem_wen);
        end
        step();
        d_req_we = 1'b0;
        settle();
        tests_run++;
        if (d_resp_valid !== 1'b1 || mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_ack3_read_issue: dvalid %b ren %b wen %b, expected 1 1 0",
                     d_resp_valid, mem_ren, mem_wen);
        end
        step();
        d_req_valid = 1'b0;
        settle();
        tests_run++;
        if (d_resp_valid !== 1'b1 || d_resp_data !== 32'h1122_CCDD) begin
            tests_failed++;
            $display("FAIL masked_readback: valid %b data %h, expected 1 1122ccdd", d_resp_valid, d_resp_data);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_i_pat;
        logic       prev_i, prev_d;
        exp_i_pat = 10'b10_0001_0000;
        prev_i = 1'b0; prev_d = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h14;
        d_req_valid = 1'b1; d_req_addr = 32'hC; d_req_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            tests_run++;
            if (i_req_ready !== exp_i_pat[k] || d_req_ready !== !exp_i_pat[k]) begin
                tests_failed++;
                $display("FAIL starve_grant %0d: i/d ready %b/%b, expected %b/%b",
                         k, i_req_ready, d_req_ready, exp_i_pat[k], !exp_i_pat[k]);
            end
            tests_run++;
            if (i_resp_valid !== prev_i || d_resp_valid !== prev_d) begin
                tests_failed++;
                $display("FAIL starve_resp %0d: i/d resp %b/%b, expected %b/%b",
                         k, i_resp_valid, d_resp_valid, prev_i, prev_d);
            end
            prev_i = exp_i_pat[k];
            prev_d = !exp_i_pat[k];
            step();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        i_req_valid = 1'b1; i_req_addr = 32'h10; d_req_valid = 1'b0;
        settle();
        tests_run++;
        if (i_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_grant: iready %b, expected 1", i_req_ready);
        end
        step();
        rst = 1'b1; d_req_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests_run++;
            if ({i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, mem_ren, mem_wen} !== 6'b0) begin
                tests_failed++;
                $display("FAIL rstmid_drop cycle %0d: got %b expected 000000", c,
                         {i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, mem_ren, mem_wen});
            end
            step();
        end
        rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
        settle();
        tests_run++;
        if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_after: resp %b/%b, expected 0/0", i_resp_valid, d_resp_valid);
        end
        step();
    endtask

    initial begin
        for (int w = 0; w < 64; w++) mem[w] = 32'hA000_0000 + w;
        mem_rdata = '0;
        rst = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0; d_req_mask = '0;
        step();
        test_reset();
        test_lone_fetch();
        test_priority();
        test_writes();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
